// File: rtl/lsu_bus_ctrl_pkg.sv
// lsu_bus_ctrl_pkg: shared definitions for the load/store bus controller.
//   - LSU state encoding (IDLE / REQ / DONE)
//   - access size codes derived from RV32I load/store funct3
//   - funct3 field constants and the default data width
//   - helpers: size decode and misalignment test
package lsu_bus_ctrl_pkg;

    localparam int unsigned XLEN_DEFAULT = 32;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StReq  = 2'd1,
        StDone = 2'd2
    } lsu_state_e;

    localparam logic [1:0] LSU_SIZE_B = 2'b00;
    localparam logic [1:0] LSU_SIZE_H = 2'b01;
    localparam logic [1:0] LSU_SIZE_W = 2'b10;

    // funct3[2] selects zero-extension for loads
    localparam int unsigned F3_ZEXT_BIT = 2;

    // funct3[1:0]: 00 byte, 01 half, 10/11 word
    function automatic logic [1:0] lsu_size(input logic [2:0] funct3);
        return funct3[1] ? LSU_SIZE_W : funct3[1:0];
    endfunction

    function automatic logic lsu_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        return ((size == LSU_SIZE_H) && addr_lo[0]) ||
               ((size == LSU_SIZE_W) && (addr_lo != 2'b00));
    endfunction

endpackage

// File: rtl/lsu_align.sv
// lsu_align: combinational lane steering for the load/store controller.
//   Store path: byte enables and lane-replicated write data.
//   Load path : lane extract of the bus word plus sign/zero extension.
// Ports:
//   addr_lo    in  2     low byte-address bits of the access
//   funct3     in  3     RV32I load/store funct3
//   wdata      in  XLEN  store data, low bits significant
//   rword      in  XLEN  raw bus read word
//   be         out 4     byte enables
//   wdata_lane out XLEN  replicated write data
//   rdata      out XLEN  extended load result
module lsu_align
    import lsu_bus_ctrl_pkg::*;
#(
    parameter int unsigned XLEN = XLEN_DEFAULT
) (
    input  logic [1:0]      addr_lo,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] wdata,
    input  logic [XLEN-1:0] rword,
    output logic [3:0]      be,
    output logic [XLEN-1:0] wdata_lane,
    output logic [XLEN-1:0] rdata
);

    logic [1:0]      size;
    logic            sext;
    logic [1:0]      lane;
    logic [XLEN-1:0] shifted;

    always_comb begin
        size       = lsu_size(funct3);
        sext       = ~funct3[F3_ZEXT_BIT];
        lane       = 2'b00;
        be         = 4'b1111;
        wdata_lane = wdata;
        case (size)
            LSU_SIZE_B: begin
                lane       = addr_lo;
                be         = 4'b0001 << addr_lo;
                wdata_lane = {(XLEN/8){wdata[7:0]}};
            end
            LSU_SIZE_H: begin
                // addr[0] is ignored: halves always sit on an even lane
                lane       = {addr_lo[1], 1'b0};
                be         = 4'b0011 << lane;
                wdata_lane = {(XLEN/16){wdata[15:0]}};
            end
            default: ;
        endcase

        shifted = rword >> {lane, 3'b000};
        case (size)
            LSU_SIZE_B: rdata = {{(XLEN-8){sext & shifted[7]}}, shifted[7:0]};
            LSU_SIZE_H: rdata = {{(XLEN-16){sext & shifted[15]}}, shifted[15:0]};
            default:    rdata = shifted;
        endcase
    end

endmodule

// File: rtl/lsu_bus_ctrl.sv
// lsu_bus_ctrl: turns single-cycle core data accesses into req/ack bus
// transactions, stalling the core until each access completes.
// Optional feature macro: LSU_MISALIGN_TRAP_EN (misaligned half/word accesses
// skip the bus, return 0 and pulse misalign_o).
// Ports:
//   clk, rst                 clock (rising) / async active-high reset
//   core_ce_i .. funct3_i    core access request
//   core_rdata_o             extended load data, valid in DONE
//   stall_o                  core freeze
//   bus_req_o .. bus_be_o    bus request side, held stable during REQ
//   bus_ack_i, bus_rdata_i   bus completion and read word
//   bus_err_o                one-cycle pulse in DONE after a timeout
//   misalign_o               (macro only) one-cycle pulse in DONE
module lsu_bus_ctrl
    import lsu_bus_ctrl_pkg::*;
#(
    parameter int unsigned XLEN           = XLEN_DEFAULT,
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned TO_W           = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            core_ce_i,
    input  logic            core_we_i,
    input  logic [XLEN-1:0] core_addr_i,
    input  logic [XLEN-1:0] core_wdata_i,
    input  logic [2:0]      core_funct3_i,
    output logic [XLEN-1:0] core_rdata_o,
    output logic            stall_o,
    output logic            bus_req_o,
    output logic            bus_we_o,
    output logic [XLEN-1:0] bus_addr_o,
    output logic [XLEN-1:0] bus_wdata_o,
    output logic [3:0]      bus_be_o,
    input  logic            bus_ack_i,
    input  logic [XLEN-1:0] bus_rdata_i,
    output logic            bus_err_o
`ifdef LSU_MISALIGN_TRAP_EN
    ,
    output logic            misalign_o
`endif
);

    localparam bit            ToEn   = (TIMEOUT_CYCLES != 0);
    localparam logic [TO_W-1:0] ToLast = TO_W'(TIMEOUT_CYCLES - 1);

    lsu_state_e      state_q, state_d;
    logic            we_q;
    logic [XLEN-1:0] addr_q;
    logic [XLEN-1:0] wdata_q;
    logic [2:0]      funct3_q;
    logic [TO_W-1:0] cnt_q, cnt_d;
    logic            err_q, err_d;
    logic [XLEN-1:0] rdata_q, rdata_d;
    logic            accept;
    logic            skip_bus;

    logic [3:0]      be;
    logic [XLEN-1:0] wdata_lane;
    logic [XLEN-1:0] rdata_fmt;

    lsu_align #(
        .XLEN(XLEN)
    ) u_align (
        .addr_lo   (addr_q[1:0]),
        .funct3    (funct3_q),
        .wdata     (wdata_q),
        .rword     (bus_rdata_i),
        .be        (be),
        .wdata_lane(wdata_lane),
        .rdata     (rdata_fmt)
    );

    assign accept = (state_q == StIdle) && core_ce_i;

`ifdef LSU_MISALIGN_TRAP_EN
    logic mis_q;
    assign skip_bus   = lsu_misaligned(lsu_size(core_funct3_i), core_addr_i[1:0]);
    assign misalign_o = (state_q == StDone) && mis_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mis_q <= 1'b0;
        end else if (accept) begin
            mis_q <= skip_bus;
        end
    end
`else
    assign skip_bus = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        rdata_d = rdata_q;
        stall_o = 1'b0;
        unique case (state_q)
            StIdle: begin
                stall_o = core_ce_i;
                if (core_ce_i) begin
                    cnt_d = '0;
                    err_d = 1'b0;
                    if (skip_bus) begin
                        rdata_d = '0;
                        state_d = StDone;
                    end else begin
                        state_d = StReq;
                    end
                end
            end
            StReq: begin
                stall_o = 1'b1;
                if (bus_ack_i) begin
                    rdata_d = rdata_fmt;
                    state_d = StDone;
                end else if (ToEn && (cnt_q == ToLast)) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            // The core commits here; any core_ce_i now is the same instruction.
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            err_q    <= 1'b0;
            rdata_q  <= '0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            funct3_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
            if (accept) begin
                we_q     <= core_we_i;
                addr_q   <= core_addr_i;
                wdata_q  <= core_wdata_i;
                funct3_q <= core_funct3_i;
            end
        end
    end

    assign bus_req_o    = (state_q == StReq);
    assign bus_we_o     = bus_req_o && we_q;
    assign bus_be_o     = bus_req_o ? be : 4'b0000;
    assign bus_addr_o   = {addr_q[XLEN-1:2], 2'b00};
    assign bus_wdata_o  = wdata_lane;
    assign bus_err_o    = (state_q == StDone) && err_q;
    assign core_rdata_o = rdata_q;

endmodule

// File: tb/tb_lsu_bus_ctrl.sv
module tb_lsu_bus_ctrl;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        core_ce_i, core_we_i;
    logic [31:0] core_addr_i, core_wdata_i;
    logic [2:0]  core_funct3_i;
    logic [31:0] core_rdata_o;
    logic        stall_o, bus_req_o, bus_we_o, bus_ack_i, bus_err_o;
    logic [31:0] bus_addr_o, bus_wdata_o, bus_rdata_i;
    logic [3:0]  bus_be_o;
`ifdef LSU_MISALIGN_TRAP_EN
    logic        misalign_o;
`endif

    int checks = 0;
    int failures = 0;

    lsu_bus_ctrl #(
        .XLEN(32),
        .TIMEOUT_CYCLES(TO),
        .TO_W(8)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .core_ce_i    (core_ce_i),
        .core_we_i    (core_we_i),
        .core_addr_i  (core_addr_i),
        .core_wdata_i (core_wdata_i),
        .core_funct3_i(core_funct3_i),
        .core_rdata_o (core_rdata_o),
        .stall_o      (stall_o),
        .bus_req_o    (bus_req_o),
        .bus_we_o     (bus_we_o),
        .bus_addr_o   (bus_addr_o),
        .bus_wdata_o  (bus_wdata_o),
        .bus_be_o     (bus_be_o),
        .bus_ack_i    (bus_ack_i),
        .bus_rdata_i  (bus_rdata_i),
        .bus_err_o    (bus_err_o)
`ifdef LSU_MISALIGN_TRAP_EN
        ,
        .misalign_o   (misalign_o)
`endif
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference model: access size in bytes and its natural-aligned lane.
    function automatic int nbytes(input logic [2:0] f3);
        if (f3[1:0] == 2'b00) return 1;
        if (f3[1:0] == 2'b01) return 2;
        return 4;
    endfunction

    function automatic int lane_off(input logic [2:0] f3, input logic [31:0] addr);
        int n = nbytes(f3);
        return (int'(addr % 4) / n) * n;
    endfunction

    function automatic logic [31:0] model_be(input logic [2:0] f3, input logic [31:0] addr);
        int n = nbytes(f3);
        return ((32'd1 << n) - 1) << lane_off(f3, addr);
    endfunction

    function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] wd);
        logic [31:0] r = 0;
        int n = nbytes(f3);
        for (int k = 0; k < 4; k++) r |= ((wd >> (8 * (k % n))) & 32'hFF) << (8 * k);
        return r;
    endfunction

    function automatic logic [31:0] model_rdata(input logic [2:0] f3, input logic [31:0] addr,
                                                input logic [31:0] rw);
        int n = nbytes(f3);
        logic [31:0] v = rw >> (8 * lane_off(f3, addr));
        logic [31:0] mask;
        if (n < 4) begin
            mask = (32'd1 << (8 * n)) - 1;
            v = v & mask;
            if (!f3[2] && v[8*n-1]) v = v | ~mask;
        end
        return v;
    endfunction

    function automatic bit model_mis(input logic [2:0] f3, input logic [31:0] addr);
`ifdef LSU_MISALIGN_TRAP_EN
        return (addr % nbytes(f3)) != 0;
`else
        return 0;
`endif
    endfunction

    // Entered and left at posedge+#1. delay = REQ cycles before ack; >= TO means no ack.
    task automatic access(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [31:0] rw, input int delay);
        int  cnt = 0;
        bit  mis = model_mis(f3, addr);
        bit  tmo = !mis && (delay >= TO);
        int  exp_req = mis ? 0 : (tmo ? TO : delay + 1);
        core_ce_i = 1'b1; core_we_i = we; core_funct3_i = f3;
        core_addr_i = addr; core_wdata_i = wd;
        #1;
        check_eq("stall_idle", {31'd0, stall_o}, 32'd1);
        check_eq("req_idle", {31'd0, bus_req_o}, 32'd0);
        @(posedge clk); #1;
        while (bus_req_o === 1'b1 && cnt < 12) begin
            check_eq("bus_addr", bus_addr_o, addr & 32'hFFFF_FFFC);
            check_eq("bus_be", {28'd0, bus_be_o}, model_be(f3, addr));
            check_eq("bus_we", {31'd0, bus_we_o}, {31'd0, we});
            check_eq("stall_req", {31'd0, stall_o}, 32'd1);
            if (we) check_eq("bus_wdata", bus_wdata_o, model_wdata(f3, wd));
            bus_ack_i = (cnt == delay);
            bus_rdata_i = bus_ack_i ? rw : $urandom;
            @(posedge clk); #1;
            bus_ack_i = 1'b0;
            cnt++;
        end
        check_eq("req_cycles", cnt, exp_req);
        check_eq("stall_done", {31'd0, stall_o}, 32'd0);
        check_eq("bus_err", {31'd0, bus_err_o}, {31'd0, tmo});
        if (!we) check_eq("rdata", core_rdata_o, (tmo || mis) ? 32'd0 : model_rdata(f3, addr, rw));
`ifdef LSU_MISALIGN_TRAP_EN
        check_eq("misalign", {31'd0, misalign_o}, {31'd0, mis});
`endif
        // ce still high and a stray ack in DONE must not start anything
        bus_ack_i = $urandom_range(0, 1);
        @(posedge clk); #1;
        core_ce_i = 1'b0; bus_ack_i = $urandom_range(0, 1);
        #1;
        check_eq("back_idle_req", {31'd0, bus_req_o}, 32'd0);
        check_eq("back_idle_err", {31'd0, bus_err_o}, 32'd0);
        @(posedge clk); #1;
        bus_ack_i = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        core_ce_i = 0; core_we_i = 0; core_addr_i = 0; core_wdata_i = 0; core_funct3_i = 0;
        bus_ack_i = 0; bus_rdata_i = 0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_req", {31'd0, bus_req_o}, 32'd0);
        check_eq("rst_stall", {31'd0, stall_o}, 32'd0);
        check_eq("rst_be", {28'd0, bus_be_o}, 32'd0);
        check_eq("rst_we", {31'd0, bus_we_o}, 32'd0);
        check_eq("rst_err", {31'd0, bus_err_o}, 32'd0);
        check_eq("rst_rdata", core_rdata_o, 32'd0);
        check_eq("rst_addr", bus_addr_o, 32'd0);
        check_eq("rst_wdata", bus_wdata_o, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        access(1'b0, 3'b000, 32'h103, 32'h0, 32'h80FF_1234, 0);   // LB, ack first cycle
        access(1'b1, 3'b001, 32'h202, 32'h0000_BEEF, 32'h0, 3);   // SH, 4 REQ cycles
        access(1'b0, 3'b101, 32'h2, 32'h0, 32'h9876_0000, 1);     // LHU
        access(1'b0, 3'b010, 32'h8, 32'h0, 32'hCAFE_F00D, 2);     // LW
        access(1'b0, 3'b010, 32'h40, 32'h0, 32'h1234_5678, 100);  // timeout
        access(1'b0, 3'b010, 32'h6, 32'h0, 32'hA5A5_5A5A, 0);     // misaligned LW

        // Reset between edges while in REQ
        core_ce_i = 1'b1; core_we_i = 1'b0; core_funct3_i = 3'b010; core_addr_i = 32'h10;
        @(posedge clk); #1;
        check_eq("pre_rst_req", {31'd0, bus_req_o}, 32'd1);
        core_ce_i = 1'b0;
        #2 rst = 1'b1;
        #1;
        check_eq("async_rst_req", {31'd0, bus_req_o}, 32'd0);
        check_eq("async_rst_stall", {31'd0, stall_o}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        access(1'b0, 3'b100, 32'h31, 32'h0, 32'h0000_F700, 1);    // LBU after reset

        for (int i = 0; i < 250; i++) begin
            logic        we = 1'($urandom_range(0, 1));
            logic [2:0]  f3;
            if (we) f3 = 3'($urandom_range(0, 2));
            else begin
                f3 = 3'($urandom_range(0, 5));
            end
            access(we, f3, $urandom, $urandom, $urandom,
                   ($urandom_range(0, 7) == 0) ? 50 : int'($urandom_range(0, TO - 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
